// File: rtl/branch_predict_if.sv
// Execute/fetch-side signal bundle for branch_predict_unit.
// The master drives fetch and resolve inputs; the slave returns the decisions and counters.
interface branch_predict_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] F_PC;
  logic            F_PREDICT_TAKEN;
  logic            R_VALID;
  logic [XLEN-1:0] R_PC;
  logic [4:0]      R_OPCODE_6_TO_2;
  logic [2:0]      R_FUNCT3;
  logic [XLEN-1:0] R_RS1;
  logic [XLEN-1:0] R_RS2;
  logic            R_PREDICTED;
  logic            BHT_CLEAR;
  logic            R_TAKEN;
  logic            R_MISPREDICT;
  logic [31:0]     BRANCH_COUNT;
  logic [31:0]     MISPREDICT_COUNT;

  modport master (
    output F_PC, R_VALID, R_PC, R_OPCODE_6_TO_2, R_FUNCT3, R_RS1, R_RS2, R_PREDICTED, BHT_CLEAR,
    input  F_PREDICT_TAKEN, R_TAKEN, R_MISPREDICT, BRANCH_COUNT, MISPREDICT_COUNT
  );

  modport slave (
    input  F_PC, R_VALID, R_PC, R_OPCODE_6_TO_2, R_FUNCT3, R_RS1, R_RS2, R_PREDICTED, BHT_CLEAR,
    output F_PREDICT_TAKEN, R_TAKEN, R_MISPREDICT, BRANCH_COUNT, MISPREDICT_COUNT
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution for the execute stage plus a bimodal 2-bit BHT predicting for fetch,
// with saturating branch and mispredict event counters.
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input logic            CLK,
  input logic            RESET,
  branch_predict_if.slave bp
);
  localparam int IW = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [1:0]             bht_q [BHT_ENTRIES];
  logic [1:0]             bht_d [BHT_ENTRIES];
  logic [31:0]            branch_count_q, branch_count_d;
  logic [31:0]            mispredict_count_q, mispredict_count_d;
  logic [IW-1:0]          f_idx, r_idx;
  logic                   is_branch, is_jal, is_jalr, cond, br_update;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   unused_pc_bits;

  assign f_idx = bp.F_PC[IW+1:2];
  assign r_idx = bp.R_PC[IW+1:2];
  assign unused_pc_bits = ^{bp.F_PC[XLEN-1:IW+2], bp.F_PC[1:0],
                            bp.R_PC[XLEN-1:IW+2], bp.R_PC[1:0]};

  assign is_branch = (bp.R_OPCODE_6_TO_2 == OP_BRANCH);
  assign is_jal    = (bp.R_OPCODE_6_TO_2 == OP_JAL);
  assign is_jalr   = (bp.R_OPCODE_6_TO_2 == OP_JALR);
  assign rs1_s     = bp.R_RS1;
  assign rs2_s     = bp.R_RS2;

  always_comb begin
    cond = 1'b0;
    case (bp.R_FUNCT3)
      3'b000:  cond = (bp.R_RS1 == bp.R_RS2);
      3'b001:  cond = (bp.R_RS1 != bp.R_RS2);
      3'b100:  cond = (rs1_s < rs2_s);
      3'b101:  cond = (rs1_s >= rs2_s);
      3'b110:  cond = (bp.R_RS1 < bp.R_RS2);
      3'b111:  cond = (bp.R_RS1 >= bp.R_RS2);
      default: cond = 1'b0;
    endcase
  end

  assign br_update          = bp.R_VALID & is_branch;
  assign bp.R_TAKEN         = bp.R_VALID & (is_jal | is_jalr | (is_branch & cond));
  assign bp.R_MISPREDICT    = br_update & (cond != bp.R_PREDICTED);
  assign bp.F_PREDICT_TAKEN = bht_q[f_idx][1];
  assign bp.BRANCH_COUNT     = branch_count_q;
  assign bp.MISPREDICT_COUNT = mispredict_count_q;

  // Clear outranks a same-cycle training update; the event counters ignore clear.
  always_comb begin
    bht_d = bht_q;
    if (bp.BHT_CLEAR) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_d[i] = INIT_STATE;
    end else if (br_update) begin
      bht_d[r_idx] = sat_step(bht_q[r_idx], cond);
    end
    branch_count_d     = br_update ? sat_inc32(branch_count_q) : branch_count_q;
    mispredict_count_d = bp.R_MISPREDICT ? sat_inc32(mispredict_count_q) : mispredict_count_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= INIT_STATE;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      bht_q              <= bht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven and sequence checks for branch_predict_unit, with a scoreboard queue
// holding the expected resolve decisions for each driven instruction.
module tb_branch_predict_unit;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_IMM  = 5'b00100;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  branch_predict_if #(.XLEN(32)) bp ();
  branch_predict_if #(.XLEN(64)) bp64 ();

  branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .INIT_STATE(2'b01)) dut (
    .CLK(CLK), .RESET(RESET), .bp(bp)
  );
  branch_predict_unit #(.XLEN(64), .BHT_ENTRIES(16), .INIT_STATE(2'b01)) dut64 (
    .CLK(CLK), .RESET(RESET), .bp(bp64)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic taken;
    logic mis;
    int   id;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        vld;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        t;
    logic        m;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic sb_check(input logic t, input logic m);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got output with no expectation, expected queued entry");
      return;
    end
    e = sb.pop_front();
    chk($sformatf("r_taken_%0d", e.id), 64'(t), 64'(e.taken));
    chk($sformatf("r_mispredict_%0d", e.id), 64'(m), 64'(e.mis));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic resolve32(input int id, input logic vld, input logic [31:0] pc,
                           input logic [4:0] op, input logic [2:0] f3,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic pred, input logic exp_t_, input logic exp_m);
    bp.R_VALID = vld; bp.R_PC = pc; bp.R_OPCODE_6_TO_2 = op; bp.R_FUNCT3 = f3;
    bp.R_RS1 = rs1; bp.R_RS2 = rs2; bp.R_PREDICTED = pred;
    sb.push_back('{exp_t_, exp_m, id});
    #1;
    sb_check(bp.R_TAKEN, bp.R_MISPREDICT);
  endtask

  task automatic resolve64(input int id, input logic [2:0] f3,
                           input logic [63:0] rs1, input logic [63:0] rs2,
                           input logic pred, input logic exp_t_, input logic exp_m);
    bp64.R_VALID = 1'b1; bp64.R_PC = 64'h1000; bp64.R_OPCODE_6_TO_2 = OP_BR;
    bp64.R_FUNCT3 = f3; bp64.R_RS1 = rs1; bp64.R_RS2 = rs2; bp64.R_PREDICTED = pred;
    sb.push_back('{exp_t_, exp_m, id});
    #1;
    sb_check(bp64.R_TAKEN, bp64.R_MISPREDICT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_bc;
    int exp_mc;
    bp.F_PC = '0; bp.R_VALID = 1'b0; bp.R_PC = '0; bp.R_OPCODE_6_TO_2 = OP_IMM;
    bp.R_FUNCT3 = '0; bp.R_RS1 = '0; bp.R_RS2 = '0; bp.R_PREDICTED = 1'b0; bp.BHT_CLEAR = 1'b0;
    bp64.F_PC = '0; bp64.R_VALID = 1'b0; bp64.R_PC = '0; bp64.R_OPCODE_6_TO_2 = OP_IMM;
    bp64.R_FUNCT3 = '0; bp64.R_RS1 = '0; bp64.R_RS2 = '0; bp64.R_PREDICTED = 1'b0;
    bp64.BHT_CLEAR = 1'b0;

    vecs[0]  = '{1'b1, OP_BR,   3'b000, 32'd5,         32'd5,         1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, OP_BR,   3'b000, 32'd5,         32'd6,         1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, OP_BR,   3'b001, 32'd5,         32'd6,         1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, OP_BR,   3'b001, 32'd7,         32'd7,         1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, OP_BR,   3'b100, 32'hFFFF_FFFF, 32'd1,         1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, OP_BR,   3'b110, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, OP_BR,   3'b111, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, OP_BR,   3'b101, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, OP_BR,   3'b101, 32'd1,         32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, OP_BR,   3'b110, 32'd1,         32'h8000_0000, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, OP_BR,   3'b010, 32'd5,         32'd5,         1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, OP_BR,   3'b011, 32'd5,         32'd5,         1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, OP_JAL,  3'b000, 32'd0,         32'd0,         1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, OP_JALR, 3'b000, 32'd0,         32'd0,         1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, OP_IMM,  3'b000, 32'd5,         32'd5,         1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, OP_BR,   3'b000, 32'd5,         32'd5,         1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    bp.F_PC = 32'h100;
    #1;
    chk("reset_predict", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    chk("reset_branch_count", 64'(bp.BRANCH_COUNT), 64'd0);
    chk("reset_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd0);
    chk("reset_taken_idle", 64'(bp.R_TAKEN), 64'd0);
    chk("reset_mispredict_idle", 64'(bp.R_MISPREDICT), 64'd0);

    // Decode/condition table; PC 0x200+4i lands on BHT index i
    exp_bc = 0;
    exp_mc = 0;
    for (int i = 0; i < 16; i++) begin
      resolve32(i, vecs[i].vld, 32'h200 + 32'(4 * i), vecs[i].op, vecs[i].f3,
                vecs[i].rs1, vecs[i].rs2, vecs[i].pred, vecs[i].t, vecs[i].m);
      if (vecs[i].vld && vecs[i].op == OP_BR) exp_bc++;
      if (vecs[i].m) exp_mc++;
      step();
    end
    bp.R_VALID = 1'b0;
    bp.F_PC = 32'h200;
    #1;
    chk("table_branch_count", 64'(bp.BRANCH_COUNT), 64'(exp_bc));
    chk("table_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'(exp_mc));
    chk("table_predict_idx0", 64'(bp.F_PREDICT_TAKEN), 64'd1);

    // Asynchronous reset pulse between clock edges
    step();
    RESET = 1'b1;
    #1;
    chk("async_reset_branch_count", 64'(bp.BRANCH_COUNT), 64'd0);
    chk("async_reset_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd0);
    chk("async_reset_predict", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    #1;
    RESET = 1'b0;

    // First BEQ at 0x100: mispredicted taken; same-cycle read still sees old counter
    bp.F_PC = 32'h100;
    resolve32(100, 1'b1, 32'h100, OP_BR, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
    chk("same_cycle_old_predict", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    step();
    chk("beq_predict_after", 64'(bp.F_PREDICT_TAKEN), 64'd1);
    chk("beq_branch_count", 64'(bp.BRANCH_COUNT), 64'd1);
    chk("beq_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd1);

    // Saturation: four more taken (five total), then two not-taken
    for (int k = 0; k < 4; k++) begin
      resolve32(101 + k, 1'b1, 32'h100, OP_BR, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
      step();
      chk($sformatf("sat_taken_predict_%0d", k), 64'(bp.F_PREDICT_TAKEN), 64'd1);
    end
    resolve32(105, 1'b1, 32'h100, OP_BR, 3'b000, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1);
    step();
    chk("sat_first_nt_predict", 64'(bp.F_PREDICT_TAKEN), 64'd1);
    resolve32(106, 1'b1, 32'h100, OP_BR, 3'b000, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1);
    step();
    chk("sat_second_nt_predict", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    chk("sat_branch_count", 64'(bp.BRANCH_COUNT), 64'd7);
    chk("sat_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd3);

    // Jumps: always redirect, never train or count
    resolve32(107, 1'b1, 32'h100, OP_JAL, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step();
    resolve32(108, 1'b1, 32'h100, OP_JALR, 3'b000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("jump_predict_unchanged", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    chk("jump_branch_count", 64'(bp.BRANCH_COUNT), 64'd7);
    chk("jump_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd3);

    // Train index 1, then clear together with a taken update at index 0
    resolve32(109, 1'b1, 32'h104, OP_BR, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
    step();
    bp.F_PC = 32'h104;
    #1;
    chk("pre_clear_predict_104", 64'(bp.F_PREDICT_TAKEN), 64'd1);
    bp.BHT_CLEAR = 1'b1;
    resolve32(110, 1'b1, 32'h100, OP_BR, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
    step();
    bp.BHT_CLEAR = 1'b0;
    bp.R_VALID = 1'b0;
    #1;
    chk("clear_predict_104", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    bp.F_PC = 32'h100;
    #1;
    chk("clear_predict_100", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    chk("clear_branch_count", 64'(bp.BRANCH_COUNT), 64'd9);
    chk("clear_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd4);

    // Invalid branch: no outputs, no state change
    resolve32(111, 1'b0, 32'h100, OP_BR, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    step();
    chk("invalid_predict", 64'(bp.F_PREDICT_TAKEN), 64'd0);
    chk("invalid_branch_count", 64'(bp.BRANCH_COUNT), 64'd9);
    chk("invalid_mispredict_count", 64'(bp.MISPREDICT_COUNT), 64'd4);

    // XLEN = 64 signed/unsigned compares
    resolve64(200, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 1'b0);
    step();
    resolve64(201, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    step();
    resolve64(202, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b1, 1'b0);
    step();
    resolve64(203, 3'b100, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 1'b1, 1'b1, 1'b0);
    step();
    resolve64(204, 3'b110, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0);
    step();
    resolve64(205, 3'b000, 64'h0000_0001_0000_0005, 64'd5, 1'b0, 1'b0, 1'b0);
    step();
    bp64.R_VALID = 1'b0;
    #1;
    chk("x64_branch_count", 64'(bp64.BRANCH_COUNT), 64'd6);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch decision and prediction unit for the Steel Core pipeline. It resolves conditional branches, JAL and JALR in the execute stage with configurable XLEN. It also holds a bimodal branch history table (BHT) of 2-bit saturating counters that supplies a taken/not-taken prediction to fetch. It flags mispredictions and keeps branch and mispredict performance counters.

## Interface
Parameters:
- XLEN, 32, operand and PC width (32 or 64).
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, 2 to 1024.
- INIT_STATE, 2'b01, counter value after reset or clear (01 = weakly not-taken).

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- F_PC  input  XLEN  fetch-stage PC.
- F_PREDICT_TAKEN  output  1  prediction for F_PC; combinational.
- R_VALID  input  1  execute-stage instruction is valid and not flushed.
- R_PC  input  XLEN  PC of the execute-stage instruction.
- R_OPCODE_6_TO_2  input  5  opcode bits [6:2].
- R_FUNCT3  input  3  funct3 field.
- R_RS1, R_RS2  input  XLEN  source operands.
- R_PREDICTED  input  1  prediction made for this instruction at fetch, piped down.
- BHT_CLEAR  input  1  synchronous clear of the whole BHT.
- R_TAKEN  output  1  actual PC redirect decision; combinational.
- R_MISPREDICT  output  1  conditional branch outcome differs from R_PREDICTED; combinational.
- BRANCH_COUNT  output  32  number of resolved conditional branches.
- MISPREDICT_COUNT  output  32  number of mispredicted conditional branches.

## Operation
- Index: IDX = PC[log2(BHT_ENTRIES)+1 : 2]. Fetch uses F_PC; resolve uses R_PC.
- Prediction: F_PREDICT_TAKEN = BHT[IDX(F_PC)][1].
- Decode from R_OPCODE_6_TO_2:
  - 11000 is a conditional branch.
  - 11011 is JAL.
  - 11001 is JALR.
  - Anything else is not a control-flow instruction.
- Conditions, all computed on XLEN bits:
  - funct3 000: eq.
  - funct3 001: ne.
  - funct3 100: lt, signed.
  - funct3 101: ge, signed.
  - funct3 110: ltu, unsigned.
  - funct3 111: geu, unsigned.
  - funct3 010 and 011: condition is 0.
- R_TAKEN = R_VALID & (JAL | JALR | (branch & condition)). It is 0 for every other opcode.
- R_MISPREDICT = R_VALID & branch & (condition != R_PREDICTED). Jumps never raise it.
- BHT update, on each edge where R_VALID & branch:
  - Condition true: BHT[IDX(R_PC)] increments, saturating at 11.
  - Condition false: it decrements, saturating at 00.
  - Jumps and invalid cycles do not touch the BHT.
- BHT_CLEAR: every entry loads INIT_STATE on the next edge. Clear has priority over a same-cycle update. Performance counters are not affected.
- BRANCH_COUNT increments on each edge with R_VALID & branch.
- MISPREDICT_COUNT increments on each edge with R_MISPREDICT.
- Both counters saturate at 32'hFFFFFFFF and never wrap.
- RESET, asynchronous:
  - All BHT entries load INIT_STATE and both counters load 0.
  - After reset, F_PREDICT_TAKEN = INIT_STATE[1].
  - R_TAKEN and R_MISPREDICT are 0 while R_VALID = 0.

## Timing
- R_TAKEN, R_MISPREDICT and F_PREDICT_TAKEN are combinational with zero latency.
- A BHT update is visible to F_PREDICT_TAKEN in the cycle after the edge.
- Same-cycle fetch read and resolve write to one index: the read returns the old value.
- Counter outputs reflect an event one cycle after it (registered).
- RESET asserted mid-operation clears state immediately, regardless of CLK. The first update after deassertion occurs on the first rising edge with RESET low.
- Only one resolve per cycle. There are no stalls and no backpressure.

## Test plan
- Reset, then drive F_PC = 0x100 with INIT_STATE 01 -> F_PREDICT_TAKEN = 0. Both counters = 0.
- BEQ at R_PC = 0x100, RS1 = RS2 = 5, R_PREDICTED = 0, R_VALID = 1:
  - Immediately: R_TAKEN = 1, R_MISPREDICT = 1.
  - Next cycle: F_PREDICT_TAKEN at F_PC = 0x100 = 1, BRANCH_COUNT = 1, MISPREDICT_COUNT = 1.
- Signed versus unsigned compare with RS1 = 0xFFFFFFFF, RS2 = 1:
  - BLT gives R_TAKEN = 1.
  - BLTU gives R_TAKEN = 0.
  - BGEU gives R_TAKEN = 1.
  - Repeat with XLEN = 64 using sign-bit operands.
- Saturation:
  - Four taken branches at one index -> counter 11.
  - A fifth taken branch keeps it at 11.
  - Then one not-taken branch -> 10, and F_PREDICT_TAKEN stays 1.
- JAL and JALR with R_PREDICTED = 0 -> R_TAKEN = 1, R_MISPREDICT = 0. The BHT and both counters are unchanged.
- Corner cases:
  - BHT_CLEAR in the same cycle as a taken update -> the entry equals INIT_STATE and BRANCH_COUNT still increments.
  - RESET pulsed between clock edges -> all state reinitialised immediately.
  - R_VALID = 0 on a branch -> no outputs asserted and no state change.
